// File: rtl/instruction_store.sv
// instruction_store: word-addressed program store for the IF stage.
// Loads a HALT-terminated program through a valid/ready stream, then serves
// registered fetches from a byte-addressed PC. Fetches past the end of the
// program return HALT_WORD and raise an out-of-range flag.
module instruction_store #(
  parameter int          REG_SIZE  = 32,
  parameter int          DEPTH     = 64,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int          PC_W      = $clog2(DEPTH) + 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_clear,
  input  logic                     i_load_valid,
  input  logic [REG_SIZE-1:0]      i_load_data,
  output logic                     o_load_ready,
  input  logic                     i_start,
  input  logic [PC_W-1:0]          i_pc,
  output logic [REG_SIZE-1:0]      o_instruction,
  output logic                     o_loaded,
  output logic                     o_running,
  output logic [$clog2(DEPTH):0]   o_program_size,
  output logic                     o_load_overflow,
  output logic                     o_pc_misaligned,
  output logic                     o_pc_out_of_range
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;

  localparam logic [REG_SIZE-1:0] W_HALT = REG_SIZE'(HALT_WORD);
  localparam logic [AW-1:0]       LAST_PTR = AW'(DEPTH - 1);
  localparam logic [SW-1:0]       FULL_SIZE = SW'(DEPTH);

  typedef enum logic [1:0] {
    S_LOAD     = 2'd0,
    S_READY    = 2'd1,
    S_RUN      = 2'd2,
    S_OVERFLOW = 2'd3
  } state_t;

  state_t              r_state;
  logic [AW-1:0]       r_wr_ptr;
  logic [SW-1:0]       r_program_size;
  logic [REG_SIZE-1:0] r_instruction;
  logic                r_load_overflow;
  logic                r_pc_misaligned;
  logic                r_pc_out_of_range;
  logic [REG_SIZE-1:0] r_mem [DEPTH];

  logic                w_accept;
  logic                w_is_halt;
  logic [AW-1:0]       w_idx;
  logic                w_in_range;

  // A word is taken only in LOAD, and never in a cycle that is being flushed.
  assign o_load_ready = (r_state == S_LOAD);
  assign w_accept     = i_load_valid && o_load_ready && !i_clear;
  assign w_is_halt    = (i_load_data == W_HALT);
  assign w_idx        = i_pc[PC_W-1:2];
  assign w_in_range   = ({1'b0, w_idx} < r_program_size);

  assign o_instruction     = r_instruction;
  assign o_loaded          = (r_state == S_READY) || (r_state == S_RUN);
  assign o_running         = (r_state == S_RUN);
  assign o_program_size    = r_program_size;
  assign o_load_overflow   = r_load_overflow;
  assign o_pc_misaligned   = r_pc_misaligned;
  assign o_pc_out_of_range = r_pc_out_of_range;

  // Program storage: written only by accepted loader words, never reset.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= i_load_data;
    end
  end

  // Control FSM with registered fetch output and status flags.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state           <= S_LOAD;
      r_wr_ptr          <= '0;
      r_program_size    <= '0;
      r_instruction     <= '0;
      r_load_overflow   <= 1'b0;
      r_pc_misaligned   <= 1'b0;
      r_pc_out_of_range <= 1'b0;
    end else if (i_clear) begin
      r_state           <= S_LOAD;
      r_wr_ptr          <= '0;
      r_program_size    <= '0;
      r_instruction     <= '0;
      r_load_overflow   <= 1'b0;
      r_pc_misaligned   <= 1'b0;
      r_pc_out_of_range <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            if (w_is_halt) begin
              r_program_size <= {1'b0, r_wr_ptr} + SW'(1);
              r_state        <= S_READY;
            end else if (r_wr_ptr == LAST_PTR) begin
              r_program_size  <= FULL_SIZE;
              r_load_overflow <= 1'b1;
              r_instruction   <= W_HALT;
              r_state         <= S_OVERFLOW;
            end else begin
              r_wr_ptr <= r_wr_ptr + AW'(1);
            end
          end
        end
        S_READY: begin
          r_instruction <= r_mem[0];
          if (i_start) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_instruction     <= w_in_range ? r_mem[w_idx] : W_HALT;
          r_pc_out_of_range <= !w_in_range;
          r_pc_misaligned   <= (i_pc[1:0] != 2'b00);
        end
        S_OVERFLOW: begin
          r_instruction <= W_HALT;
        end
        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_store.sv
// tb_instruction_store: directed test-plan sequences followed by randomized
// traffic, all checked against a queue-based behavioural model.
module tb_instruction_store;

  localparam int          REG_SIZE = 32;
  localparam int          DEPTH    = 4;
  localparam int          PC_W     = $clog2(DEPTH) + 2;
  localparam logic [31:0] HALT     = 32'hFFFF_FFFF;

  logic                   clk;
  logic                   resetN;
  logic                   clear;
  logic                   loadValid;
  logic [REG_SIZE-1:0]    loadData;
  logic                   loadReady;
  logic                   start;
  logic [PC_W-1:0]        pc;
  logic [REG_SIZE-1:0]    instruction;
  logic                   loaded;
  logic                   running;
  logic [$clog2(DEPTH):0] programSize;
  logic                   loadOverflow;
  logic                   pcMisaligned;
  logic                   pcOutOfRange;

  instruction_store #(
    .REG_SIZE (REG_SIZE),
    .DEPTH    (DEPTH),
    .HALT_WORD(HALT),
    .PC_W     (PC_W)
  ) dut (
    .i_clk            (clk),
    .i_reset_n        (resetN),
    .i_clear          (clear),
    .i_load_valid     (loadValid),
    .i_load_data      (loadData),
    .o_load_ready     (loadReady),
    .i_start          (start),
    .i_pc             (pc),
    .o_instruction    (instruction),
    .o_loaded         (loaded),
    .o_running        (running),
    .o_program_size   (programSize),
    .o_load_overflow  (loadOverflow),
    .o_pc_misaligned  (pcMisaligned),
    .o_pc_out_of_range(pcOutOfRange)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef enum {M_LOAD, M_READY, M_RUN, M_OVF} mode_t;

  mode_t       mode;
  logic [31:0] prog[$];
  int          mSize;
  logic [31:0] expInstr;
  bit          expOvf;
  bit          expMis;
  bit          expOor;
  int          total;
  int          bad;

  // Count one comparison and report it when it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Model: back to an empty program in the load phase.
  task automatic modelReset();
    mode     = M_LOAD;
    prog.delete();
    mSize    = 0;
    expInstr = '0;
    expOvf   = 0;
    expMis   = 0;
    expOor   = 0;
  endtask

  // Model: what one rising edge does with the inputs currently driven.
  task automatic modelEdge();
    int idx;
    if (clear) begin
      modelReset();
    end else begin
      case (mode)
        M_LOAD: begin
          if (loadValid) begin
            prog.push_back(loadData);
            if (loadData == HALT) begin
              mSize = prog.size();
              mode  = M_READY;
            end else if (prog.size() == DEPTH) begin
              mSize    = DEPTH;
              expOvf   = 1;
              expInstr = HALT;
              mode     = M_OVF;
            end
          end
        end
        M_READY: begin
          expInstr = prog[0];
          if (start) mode = M_RUN;
        end
        M_RUN: begin
          idx      = int'(pc) / 4;
          expInstr = (idx < mSize) ? prog[idx] : HALT;
          expOor   = (idx >= mSize);
          expMis   = (int'(pc) % 4) != 0;
        end
        default: begin
          expInstr = HALT;
        end
      endcase
    end
  endtask

  // Compare every output against the model.
  task automatic checkAll(input string tag);
    checkOutput({tag, ".instr"},     instruction, expInstr);
    checkOutput({tag, ".ready"},     {31'b0, loadReady}, {31'b0, mode == M_LOAD});
    checkOutput({tag, ".loaded"},    {31'b0, loaded}, {31'b0, (mode == M_READY) || (mode == M_RUN)});
    checkOutput({tag, ".running"},   {31'b0, running}, {31'b0, mode == M_RUN});
    checkOutput({tag, ".size"},      32'(programSize), 32'(mSize));
    checkOutput({tag, ".overflow"},  {31'b0, loadOverflow}, {31'b0, expOvf});
    checkOutput({tag, ".misalign"},  {31'b0, pcMisaligned}, {31'b0, expMis});
    checkOutput({tag, ".oor"},       {31'b0, pcOutOfRange}, {31'b0, expOor});
  endtask

  // Drive one cycle of inputs, advance model and DUT by one edge, then check.
  task automatic applyStimulus(input string tag, input bit clr, input bit v,
                               input logic [31:0] d, input bit st,
                               input logic [PC_W-1:0] p);
    clear     = clr;
    loadValid = v;
    loadData  = d;
    start     = st;
    pc        = p;
    modelEdge();
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    clear     = 0;
    loadValid = 0;
    loadData  = '0;
    start     = 0;
    pc        = '0;
    resetN    = 0;
    modelReset();
    #12;
    checkAll("reset");
    resetN = 1;

    // Basic load of two words plus HALT, then READY presents mem[0].
    applyStimulus("ld0", 0, 1, 32'h1111_1111, 0, 0);
    applyStimulus("ld1", 0, 1, 32'h2222_2222, 0, 0);
    applyStimulus("ldH", 0, 1, HALT, 0, 0);
    applyStimulus("rdy", 0, 0, 32'h0, 0, 0);
    checkOutput("rdy.mem0", instruction, 32'h1111_1111);

    // Start, then aligned and misaligned fetches.
    applyStimulus("start", 0, 0, 32'h0, 1, 0);
    applyStimulus("pc0",   0, 0, 32'h0, 0, 4'd0);
    applyStimulus("pc4",   0, 0, 32'h0, 0, 4'd4);
    applyStimulus("pc8",   0, 0, 32'h0, 0, 4'd8);
    applyStimulus("pc12",  0, 0, 32'h0, 0, 4'd12);
    checkOutput("pc12.oorFixed", {31'b0, pcOutOfRange}, 32'd1);
    applyStimulus("pc6",   0, 1, 32'h5555_5555, 1, 4'd6);
    checkOutput("pc6.instrFixed", instruction, 32'h2222_2222);
    applyStimulus("pc4b",  0, 0, 32'h0, 0, 4'd4);

    // Overflow: DEPTH non-HALT words, then a further word is refused.
    applyStimulus("clr0", 1, 0, 32'h0, 0, 0);
    for (int i = 0; i < DEPTH; i++) applyStimulus("ovfLd", 0, 1, 32'hA000_0000 + i, 0, 0);
    applyStimulus("ovf5th", 0, 1, 32'hBEEF_0005, 1, 0);
    checkOutput("ovf.sizeFixed", 32'(programSize), DEPTH);

    // Gapped loading, clear racing a valid word, then reload.
    applyStimulus("clr1", 1, 0, 32'h0, 0, 0);
    applyStimulus("gapA", 0, 1, 32'h0000_00A1, 0, 0);
    applyStimulus("gap0", 0, 0, HALT, 0, 0);
    applyStimulus("gapB", 0, 1, 32'h0000_00B2, 0, 0);
    applyStimulus("gap1", 0, 0, HALT, 1, 0);
    applyStimulus("clrV", 1, 1, HALT, 0, 0);
    applyStimulus("reA",  0, 1, 32'hAAAA_AAAA, 0, 0);
    applyStimulus("reH",  0, 1, HALT, 0, 0);
    checkOutput("re.sizeFixed", 32'(programSize), 32'd2);
    applyStimulus("reRdy", 0, 0, 32'h0, 1, 0);
    applyStimulus("reRun", 0, 0, 32'h0, 0, 4'd0);
    applyStimulus("reOor", 0, 0, 32'h0, 0, 4'd9);

    // Asynchronous reset between clock edges while running.
    #3;
    resetN = 0;
    modelReset();
    #1;
    checkAll("async");
    #2;
    resetN = 1;
    applyStimulus("ignStart", 0, 0, 32'h0, 1, 0);

    // Randomized traffic over all phases.
    for (int c = 0; c < 400; c++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 3) == 0) ? HALT : $urandom;
      applyStimulus("rand", $urandom_range(0, 29) == 0, 1'($urandom_range(0, 1)),
                    d, $urandom_range(0, 3) == 0, PC_W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
